lsu_mem_ctrl: RTL and testbench

Load/store unit for the MEM stage of the 5-stage RV32I pipeline. It takes the memory-op fields the decoder places in the EX/MEM register (read/write enable, load type, store type, address, store data). It runs a valid/ready request and a response handshake on the data-memory bus, and stalls the pipeline until the access completes. It produces the byte-lane write strobes, the replicated store data, and the sign/zero-extended load result for writeback.

---
 rtl/riscv_pkg.sv | 24 ++
 rtl/lsu_lane_align.sv | 50 +++++
 rtl/lsu_mem_ctrl.sv | 149 ++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I encodings for the pipeline: load/store type codes, data width
// and the load/store unit state enum.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] LOAD_WORD   = 3'b000;
    localparam logic [2:0] LOAD_HALF   = 3'b001;
    localparam logic [2:0] LOAD_BYTE   = 3'b010;
    localparam logic [2:0] LOAD_HALF_U = 3'b011;
    localparam logic [2:0] LOAD_BYTE_U = 3'b111;

    localparam logic [1:0] STORE_WORD = 2'b00;
    localparam logic [1:0] STORE_HALF = 2'b01;
    localparam logic [1:0] STORE_BYTE = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT_RSP,
        LSU_DONE
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the LSU: store strobes/replicated data and
// load lane extraction with sign/zero extension.
module lsu_lane_align
    import riscv_pkg::*;
(
    input  logic [1:0]      store_type,
    input  logic [1:0]      store_ofs,
    input  logic [XLEN-1:0] store_data,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    input  logic [2:0]      load_type,
    input  logic [1:0]      load_ofs,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] load_ext
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Half accesses ignore addr[0]; the lane is picked by addr[1] alone.
    always_comb begin
        wstrb = 4'b1111;
        wdata = store_data;
        case (store_type)
            STORE_BYTE: begin
                wstrb = 4'b0001 << store_ofs;
                wdata = {4{store_data[7:0]}};
            end
            STORE_HALF: begin
                wstrb = store_ofs[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_byte  = rdata[{load_ofs, 3'b000} +: 8];
        rd_half  = load_ofs[1] ? rdata[XLEN-1:16] : rdata[15:0];
        load_ext = rdata;
        case (load_type)
            LOAD_BYTE:   load_ext = {{(XLEN-8){rd_byte[7]}}, rd_byte};
            LOAD_BYTE_U: load_ext = {{(XLEN-8){1'b0}}, rd_byte};
            LOAD_HALF:   load_ext = {{(XLEN-16){rd_half[15]}}, rd_half};
            LOAD_HALF_U: load_ext = {{(XLEN-16){1'b0}}, rd_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store unit: valid/ready data-memory requests, pipeline stall
// and load writeback. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu_mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        load_type,
    input  logic [1:0]        store_type,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [XLEN-1:0]   mem_wdata,
    output logic              lsu_stall,
    output logic [XLEN-1:0]   load_data,
    output logic              misalign_err,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_we,
    output logic [3:0]        dmem_wstrb,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_rsp_valid,
    input  logic [XLEN-1:0]   dmem_rdata
);

    import riscv_pkg::*;

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   load_data_q, load_data_d;
    logic [2:0]        ltype_q, ltype_d;
    logic [1:0]        lofs_q, lofs_d;
    logic              op_req;
    logic              trap;
    logic [3:0]        al_wstrb;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_load;

    assign op_req = mem_read | mem_write;

`ifdef LSU_MISALIGN_TRAP_EN
    logic half_op, word_op;
    logic misalign_q, misalign_d;

    assign half_op = (mem_read && (load_type == LOAD_HALF || load_type == LOAD_HALF_U))
                  || (mem_write && store_type == STORE_HALF);
    assign word_op = (mem_read && load_type == LOAD_WORD)
                  || (mem_write && store_type == STORE_WORD);
    assign trap       = (half_op && mem_addr[0]) || (word_op && (mem_addr[1:0] != 2'b00));
    assign misalign_d = (state_q == LSU_IDLE) && op_req && trap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_q <= 1'b0;
        else        misalign_q <= misalign_d;
    end
    assign misalign_err = misalign_q;
`else
    assign trap         = 1'b0;
    assign misalign_err = 1'b0;
`endif

    lsu_lane_align u_align (
        .store_type (store_type),
        .store_ofs  (mem_addr[1:0]),
        .store_data (mem_wdata),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .load_type  (ltype_q),
        .load_ofs   (lofs_q),
        .rdata      (dmem_rdata),
        .load_ext   (al_load)
    );

    // Request fields are captured once in IDLE so they stay stable through REQ.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wstrb_d     = wstrb_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        ltype_d     = ltype_q;
        lofs_d      = lofs_q;
        case (state_q)
            LSU_IDLE: begin
                if (op_req) begin
                    if (trap) begin
                        state_d = LSU_DONE;
                    end else begin
                        state_d = LSU_REQ;
                        addr_d  = {mem_addr[ADDR_W-1:2], 2'b00};
                        we_d    = mem_write;
                        wstrb_d = mem_write ? al_wstrb : 4'b0000;
                        wdata_d = al_wdata;
                        ltype_d = load_type;
                        lofs_d  = mem_addr[1:0];
                    end
                end
            end
            LSU_REQ: begin
                if (dmem_req_ready) state_d = we_q ? LSU_DONE : LSU_WAIT_RSP;
            end
            LSU_WAIT_RSP: begin
                if (dmem_rsp_valid) begin
                    load_data_d = al_load;
                    state_d     = LSU_DONE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LSU_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wstrb_q     <= 4'b0000;
            wdata_q     <= '0;
            load_data_q <= '0;
            ltype_q     <= LOAD_WORD;
            lofs_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            ltype_q     <= ltype_d;
            lofs_q      <= lofs_d;
        end
    end

    // Valid comes straight off the state flop so reset drops it asynchronously.
    assign dmem_req_valid = (state_q == LSU_REQ);
    assign dmem_addr      = addr_q;
    assign dmem_we        = we_q;
    assign dmem_wstrb     = wstrb_q;
    assign dmem_wdata     = wdata_q;
    assign load_data      = load_data_q;
    assign lsu_stall      = op_req && (state_q != LSU_DONE);

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed cases plus randomized
// load/store traffic against an arithmetic reference model.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  load_type = 3'b000;
    logic [1:0]  store_type = 2'b00;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        lsu_stall;
    logic [31:0] load_data;
    logic        misalign_err;
    logic        dmem_req_valid;
    logic        dmem_req_ready = 1'b0;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_rsp_valid = 1'b0;
    logic [31:0] dmem_rdata = '0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ld = '0;
    bit          chk_en = 1'b0;

    lsu_mem_ctrl #(.ADDR_W(32), .XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .load_type      (load_type),
        .store_type     (store_type),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .lsu_stall      (lsu_stall),
        .load_data      (load_data),
        .misalign_err   (misalign_err),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_addr      (dmem_addr),
        .dmem_we        (dmem_we),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_wdata     (dmem_wdata),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain arithmetic on the byte address.
    function automatic logic [3:0] m_strb(input logic [1:0] st, input logic [31:0] a);
        case (st)
            2'b10:   return 4'(1 << (a % 4));
            2'b01:   return ((a % 4) >= 2) ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] st, input logic [31:0] d);
        case (st)
            2'b10:   return (d & 32'hFF) * 32'h0101_0101;
            2'b01:   return (d & 32'hFFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] lt, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v;
        case (lt)
            3'b010, 3'b111: begin
                v = (rd >> (8 * (a % 4))) & 32'hFF;
                if (lt == 3'b010 && v >= 128) v = v - 256;
            end
            3'b001, 3'b011: begin
                v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
                if (lt == 3'b001 && v >= 32768) v = v - 65536;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    // Continuous compare: load_data must always equal the last committed load.
    always @(negedge clk) begin
        if (chk_en && rst_n) chk("load_data_track", load_data, exp_ld);
    end

    task automatic do_op(input bit ld, input logic [2:0] lt, input logic [1:0] st,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int rdly, input int sdly, input bit use_lit,
                         input logic [31:0] lit_ld, input logic [3:0] lit_strb,
                         input logic [31:0] lit_wd);
        bit          trap;
        bit          acc;
        bit          acc_pend;
        bit          got;
        bit          done;
        int          n_stall;
        int          n_req;
        int          rq;
        int          rs;
        int          sz;
        logic [31:0] e_ld;
        trap = 1'b0;
        acc = 1'b0; acc_pend = 1'b0; done = 1'b0;
        n_stall = 0; n_req = 0; rq = 0; rs = 0;
        sz = ld ? ((lt == 3'b000) ? 4 : (lt == 3'b001 || lt == 3'b011) ? 2 : 1)
                : ((st == 2'b00) ? 4 : (st == 2'b01) ? 2 : 1);
`ifdef LSU_MISALIGN_TRAP_EN
        trap = (a % sz) != 0;
`endif
        e_ld = (ld && !trap) ? m_load(lt, a, rd) : exp_ld;
        mem_read = ld; mem_write = !ld; load_type = lt; store_type = st;
        mem_addr = a; mem_wdata = wd;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            got = 1'b0;
            if (acc_pend) begin acc = 1'b1; acc_pend = 1'b0; end
            if (!lsu_stall) begin
                done = 1'b1;
                chk("misalign_done", misalign_err, trap);
                if (use_lit && ld) chk("load_literal", load_data, lit_ld);
                dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
                @(posedge clk); #1;
                break;
            end
            n_stall++;
            chk("misalign_busy", misalign_err, 1'b0);
            if (dmem_req_valid) begin
                n_req++;
                chk("req_addr", dmem_addr, {a[31:2], 2'b00});
                chk("req_we", dmem_we, !ld);
                chk("req_wstrb", dmem_wstrb, ld ? 4'b0000 : m_strb(st, a));
                if (!ld) chk("req_wdata", dmem_wdata, m_wdata(st, wd));
                if (use_lit && !ld) begin
                    chk("lit_wstrb", dmem_wstrb, lit_strb);
                    chk("lit_wdata", dmem_wdata, lit_wd);
                end
                dmem_req_ready = (rq == rdly);
                rq++;
                if (dmem_req_ready) begin
                    acc_pend = 1'b1;
                    dmem_rsp_valid = 1'b0;
                end else begin
                    dmem_rsp_valid = 1'($urandom_range(0, 1));
                    dmem_rdata = $urandom;
                end
            end else if (acc) begin
                dmem_req_ready = 1'b0;
                dmem_rsp_valid = ld && (rs == sdly);
                dmem_rdata = dmem_rsp_valid ? rd : $urandom;
                got = dmem_rsp_valid;
                rs++;
            end else begin
                dmem_req_ready = 1'b0;
                dmem_rsp_valid = 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end
            @(posedge clk); #1;
            if (got) exp_ld = e_ld;
        end
        if (!done) begin
            errors++;
            $display("FAIL op_timeout actual=stuck required=done addr=%h", a);
        end
        chk("stall_cycles", n_stall, trap ? 1 : (ld ? 3 + rdly + sdly : 2 + rdly));
        chk("req_cycles", n_req, trap ? 0 : rdly + 1);
    endtask

    task automatic idle(input int n);
        mem_read = 1'b0; mem_write = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk("idle_stall", lsu_stall, 1'b0);
            chk("idle_req", dmem_req_valid, 1'b0);
            dmem_rsp_valid = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
            dmem_req_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        dmem_rsp_valid = 1'b0; dmem_req_ready = 1'b0;
    endtask

    logic [2:0]  lts [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111};
    logic [31:0] lw_lit;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", dmem_req_valid, 1'b0);
        chk("rst_we", dmem_we, 1'b0);
        chk("rst_wstrb", dmem_wstrb, 4'b0000);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        chk("rst_misalign", misalign_err, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        chk("model_sb_strb", m_strb(2'b10, 32'h1003), 4'b1000);
        chk("model_sb_wdata", m_wdata(2'b10, 32'h0000_00A5), 32'hA5A5_A5A5);
        chk("model_lb", m_load(3'b010, 32'h2002, 32'h0080_0000), 32'hFFFF_FF80);
        chk("model_lbu", m_load(3'b111, 32'h2002, 32'h0080_0000), 32'h0000_0080);
        chk("model_lh", m_load(3'b001, 32'h3002, 32'h8001_1234), 32'hFFFF_8001);
        chk("model_lhu", m_load(3'b011, 32'h3002, 32'h8001_1234), 32'h0000_8001);

        do_op(0, 3'b000, 2'b10, 32'h1003, 32'h0000_00A5, 32'h0, 0, 0, 1, 32'h0, 4'b1000, 32'hA5A5_A5A5);
        do_op(1, 3'b010, 2'b00, 32'h2002, 32'h0, 32'h0080_0000, 0, 2, 1, 32'hFFFF_FF80, 4'h0, 32'h0);
        do_op(1, 3'b111, 2'b00, 32'h2002, 32'h0, 32'h0080_0000, 0, 2, 1, 32'h0000_0080, 4'h0, 32'h0);
        do_op(1, 3'b001, 2'b00, 32'h3002, 32'h0, 32'h8001_1234, 0, 0, 1, 32'hFFFF_8001, 4'h0, 32'h0);
        do_op(1, 3'b011, 2'b00, 32'h3002, 32'h0, 32'h8001_1234, 1, 0, 1, 32'h0000_8001, 4'h0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        lw_lit = 32'h0000_8001;
`else
        lw_lit = 32'h1122_3344;
`endif
        do_op(1, 3'b000, 2'b00, 32'h4002, 32'h0, 32'h1122_3344, 0, 1, 1, lw_lit, 4'h0, 32'h0);
        do_op(0, 3'b000, 2'b00, 32'h5000, 32'hCAFE_F00D, 32'h0, 5, 0, 1, 32'h0, 4'hF, 32'hCAFE_F00D);
        idle(2);

        // Reset pulse while a request is pending, then while awaiting a response.
        mem_read = 1'b1; mem_write = 1'b0; load_type = 3'b000; mem_addr = 32'h6000;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_req", dmem_req_valid, 1'b1);
        #2 rst_n = 1'b0; exp_ld = 32'h0;
        #1 chk("rst_async_req", dmem_req_valid, 1'b0);
        chk("rst_async_load", load_data, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        exp_ld = 32'h0;
        do_op(1, 3'b000, 2'b00, 32'h6100, 32'h0, 32'h7654_3210, 0, 0, 1, 32'h7654_3210, 4'h0, 32'h0);
        mem_read = 1'b1; load_type = 3'b000; mem_addr = 32'h6200;
        @(negedge clk);
        @(negedge clk);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        chk("wait_rsp_req", dmem_req_valid, 1'b0);
        chk("wait_rsp_stall", lsu_stall, 1'b1);
        #2 rst_n = 1'b0; exp_ld = 32'h0;
        #1 chk("rst_wait_load", load_data, 32'h0);
        mem_read = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        dmem_rsp_valid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        chk("late_rsp_stall", lsu_stall, 1'b0);
        chk("late_rsp_req", dmem_req_valid, 1'b0);
        @(posedge clk); #1;
        idle(3);

        for (int i = 0; i < 300; i++) begin
            bit          ld;
            logic [2:0]  lt;
            logic [1:0]  st;
            ld = 1'($urandom_range(0, 1));
            lt = lts[$urandom_range(0, 4)];
            st = 2'($urandom_range(0, 2));
            do_op(ld, lt, st, $urandom, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), 0, 32'h0, 4'h0, 32'h0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
